// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO controller for a dual-port RAM: port A writes, port B reads.
// First-word-fall-through read side backed by a 2-entry output buffer.
module fifo_sync_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  ram_wren_a,
    output logic [ADDR_WIDTH-1:0] ram_address_a,
    output logic [DATA_WIDTH-1:0] ram_data_a,
    output logic [ADDR_WIDTH-1:0] ram_address_b,
    output logic                  ram_wren_b,
    output logic [DATA_WIDTH-1:0] ram_data_b,
    input  logic [DATA_WIDTH-1:0] ram_q_b
);

    localparam logic [ADDR_WIDTH:0] FULL_USED = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH:0]   rptr;
    logic [ADDR_WIDTH:0]   ram_used;
    logic                  pend;
    logic [1:0]            buf_cnt;
    logic [DATA_WIDTH-1:0] buf0;
    logic [DATA_WIDTH-1:0] buf1;
    logic                  accept;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [2:0]            occupancy;

    assign ram_used  = wptr - rptr;
    assign in_ready  = (ram_used != FULL_USED);
    assign accept    = in_valid & in_ready;
    assign out_valid = (buf_cnt != 2'd0);
    assign out_data  = buf0;
    assign push      = pend;
    assign pop       = out_valid & out_ready;

    // A same-cycle pop frees a slot in time for the next capture, so the
    // buffer never overflows while a word per cycle is sustained.
    assign occupancy = {2'b00, pend} + {1'b0, buf_cnt} - {2'b00, pop};
    assign issue     = (ram_used != '0) && (occupancy < 3'd2);

    assign level = {1'b0, ram_used}
                 + {{(ADDR_WIDTH+1){1'b0}}, pend}
                 + {{ADDR_WIDTH{1'b0}}, buf_cnt};

    assign ram_wren_a    = accept;
    assign ram_address_a = wptr[ADDR_WIDTH-1:0];
    assign ram_data_a    = in_data;
    assign ram_address_b = rptr[ADDR_WIDTH-1:0];
    assign ram_wren_b    = 1'b0;
    assign ram_data_b    = '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            pend    <= 1'b0;
            buf_cnt <= 2'd0;
            buf0    <= '0;
            buf1    <= '0;
        end else begin
            if (accept) begin
                wptr <= wptr + PTR_ONE;
            end
            if (issue) begin
                rptr <= rptr + PTR_ONE;
            end
            pend <= issue;

            case ({push, pop})
                2'b10: begin
                    if (buf_cnt == 2'd0) begin
                        buf0 <= ram_q_b;
                    end else begin
                        buf1 <= ram_q_b;
                    end
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    buf0    <= buf1;
                    buf_cnt <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    if (buf_cnt == 2'd1) begin
                        buf0 <= ram_q_b;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= ram_q_b;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
